// File: rtl/ddr_frame_rd_buf.sv
// ddr_frame_rd_buf
//   Read-side frame buffer for the DDR video path. It fetches one frame,
//   line by line, from the most recently completed of three DDR frame slots.
//   Each line is requested through a request/accept/done command interface.
//   Returned beats are held in a two-line FIFO and handed out as 128-bit
//   words to the streaming consumer.
//
// Ports
//   ddr_clk, ddr_rstn        clock, asynchronous active-low reset
//   rd_fsync                 consumer frame sync (level, rising edge starts a frame)
//   rd_en                    consumer pops one 128-bit word
//   vout_de, vout_data       registered output word, valid 1 cycle after rd_en
//   underflow                sticky empty-read flag (only with FRAME_RD_BUF_UNDERFLOW_EN)
//   init_done                writer has completed a full frame; gates all activity
//   i_wr_frame_idx           slot the writer is currently filling
//   ddr_rreq/ddr_raddr       line request and start address (held until ddr_rrdy)
//   ddr_rd_len               beats per request (constant)
//   ddr_rrdy, ddr_rdone      request accepted / request fully returned
//   ddr_rdata, ddr_rdata_en  returned data beat
//
// Optional feature macro: FRAME_RD_BUF_UNDERFLOW_EN adds the underflow port.
module ddr_frame_rd_buf #(
  parameter int                    ADDR_WIDTH      = 28,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET     = {ADDR_WIDTH{1'b0}},
  parameter int                    H_NUM           = 1280,
  parameter int                    V_NUM           = 720,
  parameter int                    DQ_WIDTH        = 32,
  parameter int                    LEN_WIDTH       = 32,
  parameter int                    PIX_WIDTH       = 16,
  parameter int                    LINE_ADDR_WIDTH = 22
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    rd_fsync,
  input  logic                    rd_en,
  output logic                    vout_de,
  output logic [127:0]            vout_data,
`ifdef FRAME_RD_BUF_UNDERFLOW_EN
  output logic                    underflow,
`endif
  input  logic                    init_done,
  input  logic [1:0]              i_wr_frame_idx,
  output logic                    ddr_rreq,
  output logic [ADDR_WIDTH-1:0]   ddr_raddr,
  output logic [LEN_WIDTH-1:0]    ddr_rd_len,
  input  logic                    ddr_rrdy,
  input  logic                    ddr_rdone,
  input  logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  input  logic                    ddr_rdata_en
);

  localparam int BEAT_W      = 8 * DQ_WIDTH;
  localparam int LINE_BEATS  = H_NUM * PIX_WIDTH / BEAT_W;
  localparam int WPB         = BEAT_W / 128;                 // 128-bit words per beat
  localparam int LINE_STRIDE = H_NUM * PIX_WIDTH / DQ_WIDTH;
  localparam int DEPTH       = 2 * LINE_BEATS;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int LC_W        = $clog2(V_NUM + 1);
  localparam int WSEL_W      = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_r;
  logic                fsync_d_r;
  logic [1:0]          rd_idx_r;
  logic [1:0]          pend_idx_r;
  logic                pend_r;        // frame sync seen while a request was in flight
  logic                frame_active_r;
  logic [LC_W-1:0]     line_cnt_r;
  logic [CNT_W-1:0]    out_cnt_r;     // beats still owed by the accepted request

  logic [BEAT_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [WSEL_W-1:0]   half_r;
  logic [CNT_W-1:0]    cnt_r;         // occupied beats, including a partially read one

  logic                edge_s;
  logic                start_s;
  logic                restart_s;
  logic                flush_s;
  logic                block_s;
  logic                half_last_s;
  logic                pop_s;
  logic                pop_beat_s;
  logic                push_s;
  logic                full_s;
  logic                credit_ok_s;
  logic [CNT_W:0]      used_s;
  logic [1:0]          next_idx_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [127:0]        word_s;

  assign ddr_rd_len = LEN_WIDTH'(LINE_BEATS);

  // Most recently completed slot: (i_wr_frame_idx + 2) mod 3.
  always_comb begin
    case (i_wr_frame_idx)
      2'd0:    next_idx_s = 2'd2;
      2'd1:    next_idx_s = 2'd0;
      2'd2:    next_idx_s = 2'd1;
      default: next_idx_s = 2'd2;
    endcase
  end

  assign addr_s = ADDR_OFFSET
                + (ADDR_WIDTH'(rd_idx_r) << LINE_ADDR_WIDTH)
                + ADDR_WIDTH'(line_cnt_r) * ADDR_WIDTH'(LINE_STRIDE);

  assign word_s = mem_r[rd_ptr_r][{half_r, 7'd0} +: 128];

  // Frame-sync, flush, push/pop and credit decisions for the current cycle.
  always_comb begin
    edge_s      = init_done && rd_fsync && !fsync_d_r;
    start_s     = edge_s && (state_r == ST_IDLE);
    // A sync that lands mid-request is applied once the request is fully returned.
    restart_s   = (state_r == ST_WAIT) && ddr_rdone && (pend_r || edge_s);
    flush_s     = start_s || restart_s;
    // While a restart is pending the old frame's data is neither stored nor read.
    block_s     = pend_r || (edge_s && (state_r != ST_IDLE)) || flush_s;
    half_last_s = (half_r == WSEL_W'(WPB - 1));
    full_s      = (cnt_r == CNT_W'(DEPTH));
    pop_s       = rd_en && init_done && (cnt_r != {CNT_W{1'b0}}) && !block_s;
    pop_beat_s  = pop_s && half_last_s;
    push_s      = ddr_rdata_en && !block_s && (!full_s || pop_beat_s);
    used_s      = {1'b0, cnt_r} + {1'b0, out_cnt_r};
    credit_ok_s = (used_s <= (CNT_W + 1)'(DEPTH - LINE_BEATS));
  end

  // Request FSM: frame start, line counting, address generation and sync deferral.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_r        <= ST_IDLE;
      fsync_d_r      <= 1'b0;
      rd_idx_r       <= 2'd0;
      pend_idx_r     <= 2'd0;
      pend_r         <= 1'b0;
      frame_active_r <= 1'b0;
      line_cnt_r     <= {LC_W{1'b0}};
      out_cnt_r      <= {CNT_W{1'b0}};
      ddr_rreq       <= 1'b0;
      ddr_raddr      <= {ADDR_WIDTH{1'b0}};
    end else begin
      fsync_d_r <= rd_fsync;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            rd_idx_r       <= next_idx_s;
            line_cnt_r     <= {LC_W{1'b0}};
            frame_active_r <= 1'b1;
            pend_r         <= 1'b0;
          end else if (init_done && frame_active_r &&
                       (line_cnt_r < LC_W'(V_NUM)) && credit_ok_s) begin
            state_r   <= ST_REQ;
            ddr_rreq  <= 1'b1;
            ddr_raddr <= addr_s;
          end
        end
        ST_REQ: begin
          if (edge_s) begin
            pend_r     <= 1'b1;
            pend_idx_r <= next_idx_s;
          end
          if (ddr_rrdy) begin
            state_r    <= ST_WAIT;
            ddr_rreq   <= 1'b0;
            line_cnt_r <= line_cnt_r + LC_W'(1);
            out_cnt_r  <= CNT_W'(LINE_BEATS);
          end
        end
        ST_WAIT: begin
          if (ddr_rdone) begin
            state_r   <= ST_IDLE;
            out_cnt_r <= {CNT_W{1'b0}};
            if (restart_s) begin
              rd_idx_r       <= edge_s ? next_idx_s : pend_idx_r;
              line_cnt_r     <= {LC_W{1'b0}};
              frame_active_r <= 1'b1;
              pend_r         <= 1'b0;
            end
          end else begin
            if (edge_s) begin
              pend_r     <= 1'b1;
              pend_idx_r <= next_idx_s;
            end
            if (ddr_rdata_en && (out_cnt_r != {CNT_W{1'b0}})) begin
              out_cnt_r <= out_cnt_r - CNT_W'(1);
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ddr_rreq <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage write port (no reset needed on data).
  always_ff @(posedge ddr_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ddr_rdata;
    end
  end

  // FIFO pointers, occupancy and the registered output word.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      half_r    <= {WSEL_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      vout_de   <= 1'b0;
      vout_data <= 128'd0;
    end else begin
      vout_de <= pop_s;
      if (pop_s) begin
        vout_data <= word_s;
      end
      if (flush_s) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        half_r   <= {WSEL_W{1'b0}};
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          if (half_last_s) begin
            half_r   <= {WSEL_W{1'b0}};
            rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
          end else begin
            half_r <= half_r + WSEL_W'(1);
          end
        end
        if (push_s && !pop_beat_s) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end else if (!push_s && pop_beat_s) begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
      end
    end
  end

`ifdef FRAME_RD_BUF_UNDERFLOW_EN
  // Sticky empty-read flag, cleared at every frame sync edge.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      underflow <= 1'b0;
    end else if (edge_s) begin
      underflow <= 1'b0;
    end else if (rd_en && init_done && frame_active_r && (cnt_r == {CNT_W{1'b0}})) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_frame_rd_buf.sv
// Directed testbench for ddr_frame_rd_buf: slot address table, two-line
// credit limit, word ordering, empty reads, mid-request frame sync and
// the per-frame request count.
module tb_ddr_frame_rd_buf;

  logic         clk = 1'b0;
  logic         rstn;
  logic         rd_fsync;
  logic         rd_en;
  logic         vout_de;
  logic [127:0] vout_data;
  logic         init_done;
  logic [1:0]   wr_idx;
  logic         rreq;
  logic [27:0]  raddr;
  logic [31:0]  rd_len;
  logic         rrdy;
  logic         rdone;
  logic [255:0] rdata;
  logic         rdata_en;
`ifdef FRAME_RD_BUF_UNDERFLOW_EN
  logic         underflow;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ddr_frame_rd_buf dut (
    .ddr_clk        (clk),
    .ddr_rstn       (rstn),
    .rd_fsync       (rd_fsync),
    .rd_en          (rd_en),
    .vout_de        (vout_de),
    .vout_data      (vout_data),
`ifdef FRAME_RD_BUF_UNDERFLOW_EN
    .underflow      (underflow),
`endif
    .init_done      (init_done),
    .i_wr_frame_idx (wr_idx),
    .ddr_rreq       (rreq),
    .ddr_raddr      (raddr),
    .ddr_rd_len     (rd_len),
    .ddr_rrdy       (rrdy),
    .ddr_rdone      (rdone),
    .ddr_rdata      (rdata),
    .ddr_rdata_en   (rdata_en)
  );

  typedef struct {
    logic [1:0]  wr_idx;
    logic [27:0] addr0;
    logic [27:0] addr1;
  } vec_t;

  vec_t vecs [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] beat_val(input int k);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i*32 +: 32] = {8'(k), 8'(i), 16'hC3A5};
    end
    return b;
  endfunction

  // Word j of a line whose first beat has index k0: low half of each beat first.
  function automatic logic [127:0] word_val(input int j, input int k0);
    logic [255:0] b;
    b = beat_val(k0 + j / 2);
    return (j % 2 == 0) ? b[127:0] : b[255:128];
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (rreq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic accept();
    rrdy = 1'b1;
    tick();
    rrdy = 1'b0;
  endtask

  task automatic send_beats(input int n, input int k0);
    for (int k = 0; k < n; k++) begin
      rdata_en = 1'b1;
      rdata    = beat_val(k0 + k);
      tick();
    end
    rdata_en = 1'b0;
  endtask

  task automatic finish_req();
    rdone = 1'b1;
    tick();
    rdone = 1'b0;
  endtask

  task automatic serve(input int n, input int k0);
    accept();
    send_beats(n, k0);
    finish_req();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          nreq;
    logic [27:0] last_addr;

    vecs[0] = '{wr_idx: 2'd1, addr0: 28'h0000000, addr1: 28'h0000280};
    vecs[1] = '{wr_idx: 2'd0, addr0: 28'h0800000, addr1: 28'h0800280};
    vecs[2] = '{wr_idx: 2'd2, addr0: 28'h0400000, addr1: 28'h0400280};

    rstn = 1'b0; rd_fsync = 1'b0; rd_en = 1'b0; init_done = 1'b0; wr_idx = 2'd0;
    rrdy = 1'b0; rdone = 1'b0; rdata = 256'd0; rdata_en = 1'b0;
    tick(); tick(); tick();
    check("rst_rreq", rreq, 1'b0);
    check("rst_raddr", raddr, 28'd0);
    check("rst_vout_de", vout_de, 1'b0);
    check("rst_vout_data", vout_data, 128'd0);
    check("rst_rd_len", rd_len, 32'd80);
    rstn = 1'b1;
    tick();
    init_done = 1'b1;
    tick();

    // Slot address table, two-line credit limit, and (first entry) word order.
    for (int v = 0; v < 3; v++) begin
      wr_idx   = vecs[v].wr_idx;
      rd_fsync = 1'b0;
      tick();
      rd_fsync = 1'b1;
      tick();
      check("req_after_1cyc", rreq, 1'b0);
      tick();
      check("req_after_2cyc", rreq, 1'b1);
      check("addr_line0", raddr, vecs[v].addr0);
      serve(80, 0);
      wait_req(ok);
      check("line1_req_seen", ok, 1'b1);
      check("addr_line1", raddr, vecs[v].addr1);
      serve(80, 80);
      nreq = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (rreq) nreq++;
      end
      check("credit_stall", nreq, 32'd0);

      if (v == 0) begin
        rd_en = 1'b1;
        for (int j = 0; j < 160; j++) begin
          tick();
          check("pop_de", vout_de, 1'b1);
          check("pop_data", vout_data, word_val(j, 0));
        end
        rd_en = 1'b0;
        tick();
        check("pop_de_pulse", vout_de, 1'b0);
        tick();
        check("data_hold", vout_data, word_val(159, 0));
        wait_req(ok);
        check("line2_req_seen", ok, 1'b1);
        check("addr_line2", raddr, 28'd1280);
        serve(80, 160);
      end
    end

    // Empty read right after a frame start.
    wr_idx   = 2'd1;
    rd_fsync = 1'b0;
    tick();
    rd_fsync = 1'b1;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rd_de", vout_de, 1'b0);
`ifdef FRAME_RD_BUF_UNDERFLOW_EN
    check("underflow_set", underflow, 1'b1);
`endif

    // Frame sync in the middle of a returning line.
    wait_req(ok);
    check("mid_req_seen", ok, 1'b1);
    check("mid_addr_old", raddr, 28'd0);
    accept();
    send_beats(30, 0);
    wr_idx   = 2'd0;
    rd_fsync = 1'b0;
    tick();
    rd_fsync = 1'b1;
    tick();
`ifdef FRAME_RD_BUF_UNDERFLOW_EN
    check("underflow_clr", underflow, 1'b0);
`endif
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pend_rd_blocked", vout_de, 1'b0);
    send_beats(50, 30);
    finish_req();
    wait_req(ok);
    check("restart_req_seen", ok, 1'b1);
    check("restart_addr", raddr, 28'h0800000);
    last_addr = raddr;
    serve(80, 64);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("new_data_de", vout_de, 1'b1);
    check("new_data_word", vout_data, word_val(0, 64));

    // Count every remaining request of this frame.
    nreq = 1;
    for (int r = 0; r < 800; r++) begin
      wait_req(ok);
      if (!ok) break;
      last_addr = raddr;
      nreq++;
      accept();
      finish_req();
    end
    check("frame_req_count", nreq, 32'd720);
    check("last_line_addr", last_addr, 28'h0870580);

    // init_done low: no requests, reads ignored.
    init_done = 1'b0;
    rd_fsync  = 1'b0;
    tick();
    rd_fsync = 1'b1;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rreq) nreq++;
    end
    check("init_gate_req", nreq, 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("init_gate_rd", vout_de, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
